// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and widths for the RV32I backend slice.
//   PHYS_REG_FILE_IDX_BW : physical register tag width
//   ROB_DEPTH / ROB_IDX_BW : reorder buffer depth and index width
//   mul_arb_state_e      : multiply issue arbiter FSM states
//   mul_req_t            : one multiply request (operands + tags)
//   rr_wrap_inc          : modulo-n increment used by round-robin pointers
package rv32i_pkg;

    localparam int unsigned PHYS_REG_FILE_IDX_BW = 6;
    localparam int unsigned ROB_DEPTH            = 32;
    localparam int unsigned ROB_IDX_BW           = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mul_arb_state_e;

    typedef struct packed {
        logic [31:0]                     multiplicand;
        logic [31:0]                     multiplier;
        logic [PHYS_REG_FILE_IDX_BW-1:0] dst_phys_rf_tag;
        logic [ROB_IDX_BW-1:0]           rob_entry_idx;
    } mul_req_t;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 1;
        if (nxt >= n) nxt = 0;
        return nxt;
    endfunction

endpackage

// File: rtl/rv32i_rr_arbiter.sv
// rv32i_rr_arbiter: round-robin one-hot arbiter shared by the functional
// unit issue arbiters.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_req      : per-requester request vector
//   i_adv      : the current grant was taken; move pointer past it
//   o_gnt_vld  : some requester is granted
//   o_gnt_idx  : binary index of the granted requester
//   o_gnt_oh   : one-hot grant vector
module rv32i_rr_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_BW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    output logic               o_gnt_vld,
    output logic [IDX_BW-1:0]  o_gnt_idx,
    output logic [NUM_REQ-1:0] o_gnt_oh
);

    logic [IDX_BW-1:0] rr_ptr;
    logic [IDX_BW-1:0] rr_ptr_nxt;

    // First asserted request at or after rr_ptr, searching cyclically.
    always_comb begin
        int unsigned idx;
        logic        found;
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        o_gnt_oh  = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && i_req[idx]) begin
                found         = 1'b1;
                o_gnt_vld     = 1'b1;
                o_gnt_idx     = IDX_BW'(idx);
                o_gnt_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = IDX_BW'(rr_wrap_inc(int'(o_gnt_idx), NUM_REQ));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (i_adv && o_gnt_vld) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule

// File: rtl/rv32i_mul_issue_arbiter.sv
// rv32i_mul_issue_arbiter: shares the single 4-stage pipelined multiplier
// between NUM_REQ issue queues. Round-robin grant, one multiply in flight,
// product registered and offered to the CDB with valid/ready, flush squashes
// in-flight or pending results.
//   clk, rstn               : clock, asynchronous active-low reset
//   i_flush                 : backend flush
//   i_req_* / o_req_rdy     : issue queue requests and one-hot accept
//   o_mul_* / i_mul_rdy     : issue side of the multiplier
//   i_mul_* / o_mul_res_rdy : result side of the multiplier
//   o_wb_* / i_wb_rdy       : writeback / CDB port
// Optional build macro RV32I_MUL_ZERO_BYPASS_EN: ops with a zero operand skip
// the multiplier and produce a zero result one cycle after the grant.
module rv32i_mul_issue_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned REQ_IDX_BW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        i_flush,
    input  logic [NUM_REQ-1:0]                          i_req_vld,
    input  logic [NUM_REQ-1:0][31:0]                    i_req_multiplicand,
    input  logic [NUM_REQ-1:0][31:0]                    i_req_multiplier,
    input  logic [NUM_REQ-1:0][PHYS_REG_FILE_IDX_BW-1:0] i_req_dst_phys_rf_tag,
    input  logic [NUM_REQ-1:0][ROB_IDX_BW-1:0]          i_req_rob_entry_idx,
    output logic [NUM_REQ-1:0]                          o_req_rdy,
    output logic                                        o_mul_vld,
    output logic [31:0]                                 o_mul_multiplicand,
    output logic [31:0]                                 o_mul_multiplier,
    output logic [PHYS_REG_FILE_IDX_BW-1:0]             o_mul_dst_phys_rf_tag,
    output logic [ROB_IDX_BW-1:0]                       o_mul_rob_entry_idx,
    input  logic                                        i_mul_rdy,
    input  logic                                        i_mul_vld,
    input  logic [31:0]                                 i_mul_product,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0]             i_mul_dst_phys_rf_tag,
    input  logic [ROB_IDX_BW-1:0]                       i_mul_rob_entry_idx,
    output logic                                        o_mul_res_rdy,
    output logic                                        o_wb_vld,
    output logic [31:0]                                 o_wb_data,
    output logic [PHYS_REG_FILE_IDX_BW-1:0]             o_wb_dst_phys_rf_tag,
    output logic [ROB_IDX_BW-1:0]                       o_wb_rob_entry_idx,
    input  logic                                        i_wb_rdy
);

    mul_arb_state_e                  state_q, state_d;
    logic                            kill_q;
    logic                            gnt_vld;
    logic [REQ_IDX_BW-1:0]           gnt_idx;
    logic [NUM_REQ-1:0]              gnt_oh;
    mul_req_t                        req_sel;
    logic                            zero_op;
    logic                            can_grant;
    logic                            issue_mul;
    logic                            issue;
    logic [PHYS_REG_FILE_IDX_BW-1:0] iss_tag_q;
    logic [ROB_IDX_BW-1:0]           iss_rob_q;

    rv32i_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_BW  (REQ_IDX_BW)
    ) u_rr_arbiter (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (i_req_vld),
        .i_adv     (issue),
        .o_gnt_vld (gnt_vld),
        .o_gnt_idx (gnt_idx),
        .o_gnt_oh  (gnt_oh)
    );

    always_comb begin
        req_sel.multiplicand    = i_req_multiplicand[gnt_idx];
        req_sel.multiplier      = i_req_multiplier[gnt_idx];
        req_sel.dst_phys_rf_tag = i_req_dst_phys_rf_tag[gnt_idx];
        req_sel.rob_entry_idx   = i_req_rob_entry_idx[gnt_idx];
`ifdef RV32I_MUL_ZERO_BYPASS_EN
        zero_op = (req_sel.multiplicand == '0) || (req_sel.multiplier == '0);
`else
        zero_op = 1'b0;
`endif
        // rstn gates the combinational accept so reset forces it low at once.
        can_grant = rstn && (state_q == IDLE) && gnt_vld && !i_flush;
        issue_mul = can_grant && !zero_op && i_mul_rdy;
        issue     = issue_mul || (can_grant && zero_op);

        o_req_rdy             = issue ? gnt_oh : '0;
        o_mul_vld             = issue_mul;
        o_mul_multiplicand    = req_sel.multiplicand;
        o_mul_multiplier      = req_sel.multiplier;
        o_mul_dst_phys_rf_tag = req_sel.dst_phys_rf_tag;
        o_mul_rob_entry_idx   = req_sel.rob_entry_idx;
        o_mul_res_rdy         = (state_q == BUSY) && i_mul_vld;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_mul)  state_d = BUSY;
                else if (issue) state_d = RESP;
            end
            BUSY: begin
                if (i_mul_vld) state_d = (kill_q || i_flush) ? IDLE : RESP;
            end
            RESP: begin
                if (i_flush || i_wb_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q              <= IDLE;
            kill_q               <= 1'b0;
            o_wb_vld             <= 1'b0;
            o_wb_data            <= '0;
            o_wb_dst_phys_rf_tag <= '0;
            o_wb_rob_entry_idx   <= '0;
            iss_tag_q            <= '0;
            iss_rob_q            <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        iss_tag_q <= req_sel.dst_phys_rf_tag;
                        iss_rob_q <= req_sel.rob_entry_idx;
                    end
                    // Zero-operand bypass: result is known without the multiplier.
                    if (issue && !issue_mul) begin
                        o_wb_vld             <= 1'b1;
                        o_wb_data            <= '0;
                        o_wb_dst_phys_rf_tag <= req_sel.dst_phys_rf_tag;
                        o_wb_rob_entry_idx   <= req_sel.rob_entry_idx;
                    end
                end
                BUSY: begin
                    if (i_mul_vld) begin
                        kill_q <= 1'b0;
                        if (!(kill_q || i_flush)) begin
                            o_wb_vld             <= 1'b1;
                            o_wb_data            <= i_mul_product;
                            o_wb_dst_phys_rf_tag <= i_mul_dst_phys_rf_tag;
                            o_wb_rob_entry_idx   <= i_mul_rob_entry_idx;
                        end
                    end else if (i_flush) begin
                        kill_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_flush || i_wb_rdy) o_wb_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    a_mul_vld_only_busy: assert property (@(posedge clk) disable iff (!rstn)
        i_mul_vld |-> (state_q == BUSY));

    a_mul_tags_match: assert property (@(posedge clk) disable iff (!rstn)
        ((state_q == BUSY) && i_mul_vld) |->
        ((i_mul_dst_phys_rf_tag == iss_tag_q) && (i_mul_rob_entry_idx == iss_rob_q)));

endmodule

// File: tb/tb_rv32i_mul_issue_arbiter.sv
module tb_rv32i_mul_issue_arbiter;
    import rv32i_pkg::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TW      = PHYS_REG_FILE_IDX_BW;
    localparam int unsigned RW      = ROB_IDX_BW;

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic [RW-1:0] rob;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rstn;
    logic                           i_flush;
    logic [NUM_REQ-1:0]             i_req_vld;
    logic [NUM_REQ-1:0][31:0]       i_req_multiplicand;
    logic [NUM_REQ-1:0][31:0]       i_req_multiplier;
    logic [NUM_REQ-1:0][TW-1:0]     i_req_dst_phys_rf_tag;
    logic [NUM_REQ-1:0][RW-1:0]     i_req_rob_entry_idx;
    logic [NUM_REQ-1:0]             o_req_rdy;
    logic                           o_mul_vld;
    logic [31:0]                    o_mul_multiplicand;
    logic [31:0]                    o_mul_multiplier;
    logic [TW-1:0]                  o_mul_dst_phys_rf_tag;
    logic [RW-1:0]                  o_mul_rob_entry_idx;
    logic                           i_mul_rdy;
    logic                           i_mul_vld;
    logic [31:0]                    i_mul_product;
    logic [TW-1:0]                  i_mul_dst_phys_rf_tag;
    logic [RW-1:0]                  i_mul_rob_entry_idx;
    logic                           o_mul_res_rdy;
    logic                           o_wb_vld;
    logic [31:0]                    o_wb_data;
    logic [TW-1:0]                  o_wb_dst_phys_rf_tag;
    logic [RW-1:0]                  o_wb_rob_entry_idx;
    logic                           i_wb_rdy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    exp_t        sb[$];
    logic [31:0]   op_a[NUM_REQ];
    logic [31:0]   op_b[NUM_REQ];
    logic [TW-1:0] op_t[NUM_REQ];
    logic [RW-1:0] op_r[NUM_REQ];

    always #5 clk = ~clk;

    rv32i_mul_issue_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .i_flush               (i_flush),
        .i_req_vld             (i_req_vld),
        .i_req_multiplicand    (i_req_multiplicand),
        .i_req_multiplier      (i_req_multiplier),
        .i_req_dst_phys_rf_tag (i_req_dst_phys_rf_tag),
        .i_req_rob_entry_idx   (i_req_rob_entry_idx),
        .o_req_rdy             (o_req_rdy),
        .o_mul_vld             (o_mul_vld),
        .o_mul_multiplicand    (o_mul_multiplicand),
        .o_mul_multiplier      (o_mul_multiplier),
        .o_mul_dst_phys_rf_tag (o_mul_dst_phys_rf_tag),
        .o_mul_rob_entry_idx   (o_mul_rob_entry_idx),
        .i_mul_rdy             (i_mul_rdy),
        .i_mul_vld             (i_mul_vld),
        .i_mul_product         (i_mul_product),
        .i_mul_dst_phys_rf_tag (i_mul_dst_phys_rf_tag),
        .i_mul_rob_entry_idx   (i_mul_rob_entry_idx),
        .o_mul_res_rdy         (o_mul_res_rdy),
        .o_wb_vld              (o_wb_vld),
        .o_wb_data             (o_wb_data),
        .o_wb_dst_phys_rf_tag  (o_wb_dst_phys_rf_tag),
        .o_wb_rob_entry_idx    (o_wb_rob_entry_idx),
        .i_wb_rdy              (i_wb_rdy)
    );

    // 4-stage multiplier model: accepted in stage 1, result held at stage 4
    // until released by o_mul_res_rdy.
    logic [2:0] m_cnt;
    assign i_mul_rdy = (m_cnt == 3'd0);
    assign i_mul_vld = (m_cnt == 3'd4);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt                 <= 3'd0;
            i_mul_product         <= '0;
            i_mul_dst_phys_rf_tag <= '0;
            i_mul_rob_entry_idx   <= '0;
        end else if (o_mul_vld && i_mul_rdy) begin
            m_cnt                 <= 3'd1;
            i_mul_product         <= o_mul_multiplicand * o_mul_multiplier;
            i_mul_dst_phys_rf_tag <= o_mul_dst_phys_rf_tag;
            i_mul_rob_entry_idx   <= o_mul_rob_entry_idx;
        end else if (m_cnt >= 3'd1 && m_cnt <= 3'd3) begin
            m_cnt <= m_cnt + 3'd1;
        end else if (m_cnt == 3'd4 && o_mul_res_rdy) begin
            m_cnt <= 3'd0;
        end
    end

    function automatic exp_t mk_exp(input int unsigned r);
        exp_t e;
        e.data = op_a[r] * op_b[r];
        e.tag  = op_t[r];
        e.rob  = op_r[r];
        return e;
    endfunction

    task automatic set_req(input int unsigned r, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [TW-1:0] t, input logic [RW-1:0] ro);
        op_a[r] = a; op_b[r] = b; op_t[r] = t; op_r[r] = ro;
        i_req_vld[r]             = v;
        i_req_multiplicand[r]    = a;
        i_req_multiplier[r]      = b;
        i_req_dst_phys_rf_tag[r] = t;
        i_req_rob_entry_idx[r]   = ro;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        rstn = 1'b0; i_flush = 1'b0; i_req_vld = '0; i_wb_rdy = 1'b0;
        i_req_multiplicand = '0; i_req_multiplier = '0;
        i_req_dst_phys_rf_tag = '0; i_req_rob_entry_idx = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_flush = 1'b0; i_req_vld = '0; i_wb_rdy = 1'b0;
        i_req_multiplicand = '0; i_req_multiplier = '0;
        i_req_dst_phys_rf_tag = '0; i_req_rob_entry_idx = '0;
        repeat (2) @(posedge clk); #2;
        n_vec++;
        if ({o_req_rdy, o_mul_vld, o_mul_res_rdy, o_wb_vld} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got req_rdy=%b mul_vld=%b res_rdy=%b wb_vld=%b, expected all 0",
                     o_req_rdy, o_mul_vld, o_mul_res_rdy, o_wb_vld);
        end
        n_vec++;
        if ({o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_wb: got data=%h tag=%h rob=%h, expected 0",
                     o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx);
        end
    endtask

    task automatic test_single();
        bit   done = 0;
        exp_t e, got;
        do_reset();
        i_wb_rdy = 1'b1;
        set_req(0, 1'b1, 32'd7, 32'd6, TW'(5), RW'(3));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b01) begin
            n_bad++; $display("FAIL single_grant: got %b expected 01", o_req_rdy);
        end
        n_vec++;
        if (o_mul_vld !== 1'b1 || o_mul_multiplicand !== 32'd7 || o_mul_multiplier !== 32'd6) begin
            n_bad++; $display("FAIL single_issue: got vld=%b a=%0d b=%0d expected 1/7/6",
                              o_mul_vld, o_mul_multiplicand, o_mul_multiplier);
        end
        sb.push_back(mk_exp(0));
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld = '0; #1;
            if (o_wb_vld === 1'b1) begin
                done = 1;
                n_vec++;
                if (c != 5) begin n_bad++; $display("FAIL single_latency: got %0d expected 5", c); end
                e = sb.pop_front();
                got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
                n_vec++;
                if (got !== e) begin n_bad++; $display("FAIL single_result: got %h expected %h", got, e); end
            end
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL single_timeout: got no o_wb_vld expected one"); end
        @(posedge clk); #2;
        n_vec++;
        if (o_wb_vld !== 1'b0) begin n_bad++; $display("FAIL single_wb_drop: got %b expected 0", o_wb_vld); end
    endtask

    task automatic test_contention();
        int unsigned exp_g = 0, grants = 0, results = 0, last = 0;
        exp_t        e, got;
        do_reset();
        i_wb_rdy = 1'b1;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd2, TW'(1), RW'(1));
        set_req(1, 1'b1, 32'h0001_0000, 32'h0001_0000, TW'(2), RW'(2));
        for (int unsigned c = 0; c < 120 && results < 8; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            if (grants >= 8) i_req_vld = '0;
            #1;
            if (o_req_rdy !== '0) begin
                n_vec++;
                if (o_req_rdy !== (NUM_REQ'(1) << exp_g)) begin
                    n_bad++; $display("FAIL rr_grant: got %b expected req %0d", o_req_rdy, exp_g);
                end
                if (grants > 0) begin
                    n_vec++;
                    if (c - last != 6) begin n_bad++; $display("FAIL rr_gap: got %0d expected 6", c - last); end
                end
                last = c;
                sb.push_back(mk_exp(exp_g));
                exp_g = exp_g ^ 1;
                grants++;
            end
            if (o_wb_vld === 1'b1 && i_wb_rdy) begin
                results++;
                n_vec++;
                got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL rr_result: got %h expected nothing", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_bad++; $display("FAIL rr_result: got %h expected %h", got, e); end
                end
            end
        end
        if (results < 8) begin n_vec++; n_bad++; $display("FAIL rr_timeout: got %0d results expected 8", results); end
    endtask

    task automatic test_backpressure();
        bit   done = 0;
        exp_t e, got;
        do_reset();
        i_wb_rdy = 1'b0;
        set_req(0, 1'b1, 32'd3, 32'd5, TW'(7), RW'(4));
        set_req(1, 1'b1, 32'd4, 32'd4, TW'(8), RW'(5));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b01) begin n_bad++; $display("FAIL bp_grant0: got %b expected 01", o_req_rdy); end
        sb.push_back(mk_exp(0));
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld[0] = 1'b0; #1;
            if (o_wb_vld === 1'b1) done = 1;
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL bp_timeout: got no o_wb_vld expected one"); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
            n_vec++;
            if (o_wb_vld !== 1'b1 || got !== sb[0] || o_req_rdy !== '0) begin
                n_bad++;
                $display("FAIL bp_hold: got vld=%b wb=%h req_rdy=%b expected 1/%h/00",
                         o_wb_vld, got, o_req_rdy, sb[0]);
            end
        end
        @(posedge clk); #1; i_wb_rdy = 1'b1; #1;
        got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
        e = sb.pop_front();
        n_vec++;
        if (o_wb_vld !== 1'b1 || got !== e) begin
            n_bad++; $display("FAIL bp_release: got vld=%b wb=%h expected 1/%h", o_wb_vld, got, e);
        end
        @(posedge clk); #2;
        n_vec++;
        if (o_req_rdy !== 2'b10) begin n_bad++; $display("FAIL bp_next_grant: got %b expected 10", o_req_rdy); end
        sb.push_back(mk_exp(1));
        done = 0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld = '0; #1;
            if (o_wb_vld === 1'b1) begin
                done = 1;
                e = sb.pop_front();
                got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
                n_vec++;
                if (got !== e) begin n_bad++; $display("FAIL bp_second: got %h expected %h", got, e); end
            end
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL bp_second_timeout: got no o_wb_vld expected one"); end
    endtask

    task automatic test_flush_busy();
        int unsigned res_pulses = 0, wb_seen = 0;
        bit          done = 0;
        exp_t        e, got;
        do_reset();
        i_wb_rdy = 1'b1;
        set_req(0, 1'b1, 32'd9, 32'd9, TW'(10), RW'(6));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b01) begin n_bad++; $display("FAIL fb_grant: got %b expected 01", o_req_rdy); end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1; i_req_vld = '0; i_flush = (c == 2); #1;
            if (o_mul_res_rdy === 1'b1) res_pulses++;
            if (o_wb_vld === 1'b1) wb_seen++;
        end
        i_flush = 1'b0;
        n_vec++;
        if (res_pulses != 1) begin n_bad++; $display("FAIL fb_release: got %0d pulses expected 1", res_pulses); end
        n_vec++;
        if (wb_seen != 0) begin n_bad++; $display("FAIL fb_no_wb: got %0d wb cycles expected 0", wb_seen); end
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'd2, 32'd3, TW'(11), RW'(7));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b10) begin n_bad++; $display("FAIL fb_regrant: got %b expected 10", o_req_rdy); end
        sb.push_back(mk_exp(1));
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld = '0; #1;
            if (o_wb_vld === 1'b1) begin
                done = 1;
                e = sb.pop_front();
                got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
                n_vec++;
                if (got !== e) begin n_bad++; $display("FAIL fb_after: got %h expected %h", got, e); end
            end
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL fb_after_timeout: got no o_wb_vld expected one"); end
    endtask

    task automatic test_flush_resp_and_reset();
        bit done = 0;
        do_reset();
        i_wb_rdy = 1'b0;
        set_req(0, 1'b1, 32'd5, 32'd5, TW'(12), RW'(8));
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld = '0; #1;
            if (o_wb_vld === 1'b1) done = 1;
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL fr_timeout: got no o_wb_vld expected one"); end
        @(posedge clk); #1; i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0; #1;
        n_vec++;
        if (o_wb_vld !== 1'b0) begin n_bad++; $display("FAIL fr_drop: got %b expected 0", o_wb_vld); end

        i_wb_rdy = 1'b1;
        set_req(0, 1'b1, 32'd6, 32'd7, TW'(13), RW'(9));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b01) begin n_bad++; $display("FAIL ar_grant: got %b expected 01", o_req_rdy); end
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({o_req_rdy, o_mul_vld, o_mul_res_rdy, o_wb_vld} !== '0) begin
            n_bad++;
            $display("FAIL ar_ctrl: got req_rdy=%b mul_vld=%b res_rdy=%b wb_vld=%b expected all 0",
                     o_req_rdy, o_mul_vld, o_mul_res_rdy, o_wb_vld);
        end
        n_vec++;
        if ({o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx} !== '0) begin
            n_bad++; $display("FAIL ar_wb: got data=%h tag=%h rob=%h expected 0",
                              o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx);
        end
        i_req_vld = '0;
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_zero_operand();
        int unsigned mulv = 0, lat;
        bit          done = 0;
        exp_t        e, got;
        do_reset();
        i_wb_rdy = 1'b1;
        set_req(0, 1'b1, 32'd0, 32'd123, TW'(14), RW'(10));
        #1;
        n_vec++;
        if (o_req_rdy !== 2'b01) begin n_bad++; $display("FAIL zero_grant: got %b expected 01", o_req_rdy); end
`ifdef RV32I_MUL_ZERO_BYPASS_EN
        lat = 1;
`else
        lat = 5;
`endif
        if (o_mul_vld === 1'b1) mulv++;
        sb.push_back(mk_exp(0));
        for (int unsigned c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1; i_req_vld = '0; #1;
            if (o_mul_vld === 1'b1) mulv++;
            if (o_wb_vld === 1'b1) begin
                done = 1;
                n_vec++;
                if (c != lat) begin n_bad++; $display("FAIL zero_latency: got %0d expected %0d", c, lat); end
                e = sb.pop_front();
                got = {o_wb_data, o_wb_dst_phys_rf_tag, o_wb_rob_entry_idx};
                n_vec++;
                if (got !== e) begin n_bad++; $display("FAIL zero_result: got %h expected %h", got, e); end
            end
        end
        if (!done) begin n_vec++; n_bad++; $display("FAIL zero_timeout: got no o_wb_vld expected one"); end
        n_vec++;
`ifdef RV32I_MUL_ZERO_BYPASS_EN
        if (mulv != 0) begin n_bad++; $display("FAIL zero_mul_vld: got %0d issues expected 0", mulv); end
`else
        if (mulv != 1) begin n_bad++; $display("FAIL zero_mul_vld: got %0d issues expected 1", mulv); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush_busy();
        test_flush_resp_and_reset();
        test_zero_operand();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
